// File: rtl/fixed_vec_scale.sv
// Purpose : pipelined signed fixed-point vector-by-scalar multiply, per-beat round/truncate, wrap or saturate.
// Latency : 3 register stages (S0 operands, S1 products, S2 results); a beat loaded at edge k is on out_* after edge k+2.
// Backpr. : single global advance (!out_valid || out_ready); all stages freeze together, no beat is dropped.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake; in_ready is combinational from out_ready/out_valid
//   in_a[N], in_b, in_round  lane operands, shared scalar, 0=floor / 1=round-half-up
//   out_valid/out_ready      output handshake
//   out_res[N], out_ovf[N]   lane results and per-lane overflow flags
//   ovf_sticky, ovf_clr      sticky overflow indicator and its clear (set wins)
// Optional feature: define FIXED_VEC_SCALE_SAT_EN to clamp overflowing lanes; otherwise they wrap.

module fixed_vec_scale #(
    parameter int TOTAL_PREC = 27,
    parameter int FRAC_BITS  = 22,
    parameter int NUM_LANES  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [TOTAL_PREC-1:0] in_a [NUM_LANES-1:0],
    input  logic signed [TOTAL_PREC-1:0] in_b,
    input  logic                         in_round,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [TOTAL_PREC-1:0] out_res [NUM_LANES-1:0],
    output logic [NUM_LANES-1:0]         out_ovf,
    output logic                         ovf_sticky,
    input  logic                         ovf_clr
);

    localparam int W  = TOTAL_PREC;
    localparam int F  = FRAC_BITS;
    localparam int N  = NUM_LANES;
    localparam int PW = 2 * W;

    // Half an output LSB, aligned to the full-width product.
    localparam logic [PW:0] RND = {{PW{1'b0}}, 1'b1} << (F - 1);

`ifdef FIXED_VEC_SCALE_SAT_EN
    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
`endif

    logic adv;

    // S0: registered operands
    logic                s0_vld;
    logic signed [W-1:0] s0_a [N-1:0];
    logic signed [W-1:0] s0_b;
    logic                s0_round;

    // S1: full-precision products
    logic                 s1_vld;
    logic signed [PW-1:0] s1_prod [N-1:0];
    logic                 s1_round;

    // Combinational next-stage values
    logic signed [PW-1:0] prod_n  [N-1:0];
    logic signed [PW:0]   rnd_sum [N-1:0];
    logic signed [PW:0]   quo     [N-1:0];
    logic signed [W-1:0]  res_n   [N-1:0];
    logic [N-1:0]         ovf_n;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Operands are sign-extended to the product width so the PW-bit multiply is exact.
    always_comb begin
        prod_n = '{default: '0};
        for (int i = 0; i < N; i++) begin
            prod_n[i] = $signed({{W{s0_a[i][W-1]}}, s0_a[i]}) *
                        $signed({{W{s0_b[W-1]}}, s0_b});
        end
    end

    // One guard bit above the product keeps the rounding add from overflowing.
    // A lane overflows when the bits from W-1 upward are not all sign copies.
    always_comb begin
        rnd_sum = '{default: '0};
        quo     = '{default: '0};
        res_n   = '{default: '0};
        ovf_n   = '0;
        for (int i = 0; i < N; i++) begin
            rnd_sum[i] = {s1_prod[i][PW-1], s1_prod[i]} + (s1_round ? RND : '0);
            quo[i]     = rnd_sum[i] >>> F;
            ovf_n[i]   = !((&quo[i][PW:W-1]) || !(|quo[i][PW:W-1]));
`ifdef FIXED_VEC_SCALE_SAT_EN
            if (ovf_n[i]) begin
                res_n[i] = quo[i][PW] ? SAT_MIN : SAT_MAX;
            end else begin
                res_n[i] = quo[i][W-1:0];
            end
`else
            res_n[i] = quo[i][W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld     <= 1'b0;
            s0_b       <= '0;
            s0_round   <= 1'b0;
            s1_vld     <= 1'b0;
            s1_round   <= 1'b0;
            out_valid  <= 1'b0;
            out_ovf    <= '0;
            ovf_sticky <= 1'b0;
            for (int i = 0; i < N; i++) begin
                s0_a[i]    <= '0;
                s1_prod[i] <= '0;
                out_res[i] <= '0;
            end
        end else begin
            if (adv) begin
                s0_vld    <= in_valid;
                s0_a      <= in_a;
                s0_b      <= in_b;
                s0_round  <= in_round;
                s1_vld    <= s0_vld;
                s1_prod   <= prod_n;
                s1_round  <= s0_round;
                out_valid <= s1_vld;
                out_res   <= res_n;
                // Bubbles carry no overflow so out_ovf never reflects stale data.
                out_ovf   <= s1_vld ? ovf_n : '0;
            end
            if (adv && s1_vld && (|ovf_n)) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_vec_scale.sv
// Directed bench for fixed_vec_scale (W=27, F=22, N=3); expected values are hand-computed constants.
module tb_fixed_vec_scale;

    localparam int W   = 27;
    localparam int N   = 3;
    localparam int ONE = 4194304;

`ifdef FIXED_VEC_SCALE_SAT_EN
    localparam int OV0 = 67108863;
    localparam int OV1 = -67108864;
`else
    localparam int OV0 = 0;
    localparam int OV1 = 0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_a [N-1:0];
    logic signed [W-1:0] in_b;
    logic                in_round;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_res [N-1:0];
    logic [N-1:0]        out_ovf;
    logic                ovf_sticky;
    logic                ovf_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fixed_vec_scale #(
        .TOTAL_PREC(27),
        .FRAC_BITS (22),
        .NUM_LANES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_round  (in_round),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_ovf   (out_ovf),
        .ovf_sticky(ovf_sticky),
        .ovf_clr   (ovf_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int a0, input int a1, input int a2,
                         input int b, input logic rnd);
        in_valid = v;
        in_a[0]  = a0[W-1:0];
        in_a[1]  = a1[W-1:0];
        in_a[2]  = a2[W-1:0];
        in_b     = b[W-1:0];
        in_round = rnd;
    endtask

    task automatic chk_res(input string tag, input int e0, input int e1, input int e2);
        chk({tag, "_l0"}, out_res[0], e0);
        chk({tag, "_l1"}, out_res[1], e1);
        chk({tag, "_l2"}, out_res[2], e2);
    endtask

    int   sent;
    int   rcv;
    logic fi;
    logic fo;

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk_res("rst_res", 0, 0, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_sticky", ovf_sticky, 0);

        // Basic: {1.0,-2.0,0.5} * 2.0
        drive(1'b1, ONE, -2 * ONE, ONE / 2, 2 * ONE, 1'b0);
        step();
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        chk("basic_lat1", out_valid, 0);
        step();
        chk("basic_lat2", out_valid, 0);
        step();
        chk("basic_valid", out_valid, 1);
        chk_res("basic", 8388608, -16777216, 4194304);
        chk("basic_ovf", out_ovf, 0);
        step();
        chk("basic_drain", out_valid, 0);

        // Rounding: {1,1,-1} LSB * 0.5, truncate then round, back to back
        drive(1'b1, 1, 1, -1, 2097152, 1'b0);
        step();
        drive(1'b1, 1, 1, -1, 2097152, 1'b1);
        step();
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        step();
        chk("trunc_valid", out_valid, 1);
        chk_res("trunc", 0, 0, -1);
        step();
        chk("round_valid", out_valid, 1);
        chk_res("round", 1, 1, 0);
        chk("round_sticky", ovf_sticky, 0);
        step();

        // Overflow: {8.0,-8.0,1.0} * 4.0
        drive(1'b1, 8 * ONE, -8 * ONE, ONE, 4 * ONE, 1'b0);
        step();
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        step();
        chk("ovf_sticky_pre", ovf_sticky, 0);
        step();
        chk("ovf_valid", out_valid, 1);
        chk_res("ovf", OV0, OV1, 16777216);
        chk("ovf_flags", out_ovf, 3'b011);
        chk("ovf_sticky_set", ovf_sticky, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("sticky_clr", ovf_sticky, 0);

        // Clear coincident with an overflowing beat loading S2: set wins
        drive(1'b1, 8 * ONE, -8 * ONE, ONE, 4 * ONE, 1'b0);
        step();
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        step();
        ovf_clr = 1'b1;
        step();
        chk("sticky_set_wins_valid", out_valid, 1);
        chk("sticky_set_wins", ovf_sticky, 1);
        step();
        chk("sticky_clr_alone", ovf_sticky, 0);
        ovf_clr = 1'b0;

        // Backpressure: 6 beats, out_ready low for 5 cycles mid-stream
        sent = 0;
        rcv  = 0;
        for (int t = 0; t < 60 && rcv < 6; t++) begin
            out_ready = !(t >= 3 && t <= 7);
            if (sent < 6) begin
                drive(1'b1, (sent + 1) * ONE, -(sent + 1) * ONE, sent + 1, ONE, 1'b0);
            end else begin
                drive(1'b0, 0, 0, 0, 0, 1'b0);
            end
            #1;
            if (out_valid) begin
                chk_res("bp_res", (rcv + 1) * ONE, -(rcv + 1) * ONE, rcv + 1);
                chk("bp_ovf", out_ovf, 0);
            end
            if (out_valid && !out_ready) begin
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_held3", sent - rcv, 3);
            end
            fi = in_valid && in_ready;
            fo = out_valid && out_ready;
            step();
            if (fi) sent++;
            if (fo) rcv++;
        end
        out_ready = 1'b1;
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        chk("bp_sent", sent, 6);
        chk("bp_rcvd", rcv, 6);
        chk("bp_sticky", ovf_sticky, 0);
        step();
        chk("bp_drained", out_valid, 0);

        // Reset mid-flight: sticky set, two beats in S0/S1, then one reset cycle
        drive(1'b1, 8 * ONE, -8 * ONE, ONE, 4 * ONE, 1'b0);
        step();
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        step();
        step();
        step();
        chk("mid_sticky_pre", ovf_sticky, 1);
        drive(1'b1, 3 * ONE, ONE, ONE, ONE, 1'b0);
        step();
        drive(1'b1, 5 * ONE, ONE, ONE, ONE, 1'b1);
        step();
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_out_valid", out_valid, 0);
        chk_res("mid_res", 0, 0, 0);
        chk("mid_ovf", out_ovf, 0);
        chk("mid_sticky", ovf_sticky, 0);
        chk("mid_in_ready", in_ready, 1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("mid_no_ghost", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
